// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/issue front end: control-word bit
// positions, register index width and the issue controller state encoding.
package pipe_pkg;

  localparam int REG_IDX_W = 3;

  localparam int CTRL_SRC2MUX = 6;
  localparam int CTRL_OP      = 5;
  localparam int CTRL_READ1   = 4;
  localparam int CTRL_READ2   = 3;
  localparam int CTRL_WE      = 2;
  localparam int CTRL_JMP     = 1;
  localparam int CTRL_HALT    = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } issue_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters: incremented on issue of a writing
// instruction, decremented on writeback, queried for RAW and saturation.
module reg_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int PEND_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_incEn,
  input  logic [REG_IDX_W-1:0] i_incIdx,
  input  logic                 i_decEn,
  input  logic [REG_IDX_W-1:0] i_decIdx,
  input  logic [REG_IDX_W-1:0] i_q1Idx,
  input  logic [REG_IDX_W-1:0] i_q2Idx,
  output logic                 o_busy1,
  output logic                 o_busy2,
  output logic                 o_sat1,
  output logic                 o_allZero,
  output logic                 o_err
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0]   r_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;

  assign o_busy1 = (r_cnt[i_q1Idx] != '0);
  assign o_busy2 = (r_cnt[i_q2Idx] != '0);
  assign o_sat1  = (r_cnt[i_q1Idx] == CNT_MAX);
  assign o_err   = i_decEn && (r_cnt[i_decIdx] == '0);

  always_comb begin
    w_inc     = '0;
    w_dec     = '0;
    o_allZero = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_inc[i] = i_incEn && (i_incIdx == REG_IDX_W'(i));
      w_dec[i] = i_decEn && (i_decIdx == REG_IDX_W'(i));
      if (r_cnt[i] != '0) o_allZero = 1'b0;
    end
  end

  // Same-cycle inc and dec cancel; a decrement of an empty counter is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + PEND_W'(1);
        else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - PEND_W'(1);
      end
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: owns the fetch PC, resolves jumps and halts,
// and offers hazard-free decoded instructions to register read.
module issue_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          NUM_REGS = 8,
  parameter int          PEND_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [31:0]          fetch_pc,
  input  logic                 dec_valid,
  input  logic [31:0]          dec_imm,
  input  logic [REG_IDX_W-1:0] dec_src1,
  input  logic [REG_IDX_W-1:0] dec_src2,
  input  logic [6:0]           dec_ctrl,
  input  logic [7:0]           dec_len,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_idx,
  output logic                 halted,
  output logic                 illegal,
  output logic                 sb_err
);

  issue_state_t r_state;
  issue_state_t w_stateNext;
  logic [31:0]  r_pc;
  logic [31:0]  w_pcNext;
  logic         r_illegal;
  logic         r_sbErr;
  logic         w_setIllegal;
  logic         w_busy1, w_busy2, w_sat1, w_allZero, w_sbErrPulse;
  logic         w_hazard;
  logic         w_incEn;
  logic         w_unusedOp;

  assign w_unusedOp = dec_ctrl[CTRL_OP];

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PEND_W   (PEND_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_incEn   (w_incEn),
    .i_incIdx  (dec_src1),
    .i_decEn   (wb_valid),
    .i_decIdx  (wb_idx),
    .i_q1Idx   (dec_src1),
    .i_q2Idx   (dec_src2),
    .o_busy1   (w_busy1),
    .o_busy2   (w_busy2),
    .o_sat1    (w_sat1),
    .o_allZero (w_allZero),
    .o_err     (w_sbErrPulse)
  );

  // src1 doubles as the destination, so its counter also gates saturation.
  assign w_hazard = (dec_ctrl[CTRL_READ1] && w_busy1)
                  || (dec_ctrl[CTRL_READ2] && !dec_ctrl[CTRL_SRC2MUX] && w_busy2)
                  || (dec_ctrl[CTRL_WE] && w_sat1);

  always_comb begin
    w_stateNext  = r_state;
    w_pcNext     = r_pc;
    w_setIllegal = 1'b0;
    iss_valid    = 1'b0;
    case (r_state)
      RUN: begin
        if (dec_valid) begin
          if (dec_len == 8'd0) begin
            w_setIllegal = 1'b1;
            w_stateNext  = HALTED;
          end else if (dec_ctrl[CTRL_HALT]) begin
            w_stateNext = DRAIN;
          end else if (dec_ctrl[CTRL_JMP]) begin
            w_pcNext    = r_pc + 32'(dec_len) + dec_imm;
            w_stateNext = REDIRECT;
          end else begin
            iss_valid = !w_hazard;
            if (!w_hazard && iss_ready) w_pcNext = r_pc + 32'(dec_len);
          end
        end
      end
      REDIRECT: w_stateNext = RUN;
      DRAIN:    if (w_allZero) w_stateNext = HALTED;
      HALTED:   w_stateNext = HALTED;
      default:  w_stateNext = RUN;
    endcase
  end

  assign w_incEn = iss_valid && iss_ready && dec_ctrl[CTRL_WE];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_illegal <= 1'b0;
      r_sbErr   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if (w_setIllegal) r_illegal <= 1'b1;
      if (w_sbErrPulse) r_sbErr <= 1'b1;
    end
  end

  assign fetch_pc = r_pc;
  assign halted   = (r_state == HALTED);
  assign illegal  = r_illegal;
  assign sb_err   = r_sbErr;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: vector table from reset, directed
// multi-cycle sequences, and a randomized run against a reference model.
module tb_issue_ctrl;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        dec_valid;
  logic [31:0] dec_imm;
  logic [2:0]  dec_src1, dec_src2;
  logic [6:0]  dec_ctrl;
  logic [7:0]  dec_len;
  logic        iss_valid, iss_ready;
  logic        wb_valid;
  logic [2:0]  wb_idx;
  logic        halted, illegal, sb_err;

  int nChecks = 0;
  int nFails  = 0;

  issue_ctrl dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .dec_valid(dec_valid),
    .dec_imm(dec_imm), .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_ctrl(dec_ctrl), .dec_len(dec_len), .iss_valid(iss_valid),
    .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .halted(halted), .illegal(illegal), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [6:0]  ctrl;
    logic [7:0]  len;
    logic [31:0] imm;
    logic        ready;
    logic        expValid;
    logic [31:0] expPc;
    logic        expIllegal;
    logic        expHalted2;
  } vec_t;

  vec_t vecs[10];
  logic [6:0] cMov, cAddRR, cAddI, cJmp, cHlt, cJmpHlt;

  function automatic logic [6:0] mkCtrl(input bit mux, input bit r1, input bit r2,
                                        input bit we, input bit jmp, input bit hlt);
    logic [6:0] c;
    c = '0;
    c[CTRL_SRC2MUX] = mux;
    c[CTRL_READ1]   = r1;
    c[CTRL_READ2]   = r2;
    c[CTRL_WE]      = we;
    c[CTRL_JMP]     = jmp;
    c[CTRL_HALT]    = hlt;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] ctrl, input logic [2:0] s1,
                               input logic [2:0] s2, input logic [7:0] len,
                               input logic [31:0] imm, input logic rdy);
    dec_valid = v;
    dec_ctrl  = ctrl;
    dec_src1  = s1;
    dec_src2  = s2;
    dec_len   = len;
    dec_imm   = imm;
    iss_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    wb_idx   = 3'd0;
    applyStimulus(1'b0, 7'd0, 3'd0, 3'd0, 8'd0, 32'd0, 1'b0);
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Reference model state for the randomized run
  int          mPend[8];
  logic [31:0] mPc;
  bit          mBubble, mHeld;
  logic        rV, rJ, rMux, rR1, rR2, rWe, rRdy, expV, hz;
  logic [2:0]  rS1, rS2, rWbIdx;
  logic [7:0]  rLen;
  logic [31:0] rImm;
  bit          doWb;

  initial begin
    cMov    = mkCtrl(1, 0, 0, 1, 0, 0);
    cAddRR  = mkCtrl(0, 1, 1, 1, 0, 0);
    cAddI   = mkCtrl(1, 1, 0, 1, 0, 0);
    cJmp    = mkCtrl(1, 0, 0, 0, 1, 0);
    cHlt    = mkCtrl(0, 0, 0, 0, 0, 1);
    cJmpHlt = mkCtrl(0, 0, 0, 0, 1, 1);

    //            valid ctrl     len    imm           rdy expV expPc         ill hlt2
    vecs[0] = '{1'b1, cMov,    8'd5,  32'h0,        1, 1, 32'h5,        0, 0};
    vecs[1] = '{1'b1, cMov,    8'd5,  32'h0,        0, 1, 32'h0,        0, 0};
    vecs[2] = '{1'b1, cAddRR,  8'd2,  32'h0,        1, 1, 32'h2,        0, 0};
    vecs[3] = '{1'b1, cJmp,    8'd5,  32'h10,       1, 0, 32'h15,       0, 0};
    vecs[4] = '{1'b1, cJmp,    8'd5,  32'hFFFFFFF0, 1, 0, 32'hFFFFFFF5, 0, 0};
    vecs[5] = '{1'b1, cHlt,    8'd1,  32'h0,        1, 0, 32'h0,        0, 1};
    vecs[6] = '{1'b1, cMov,    8'd0,  32'h0,        1, 0, 32'h0,        1, 1};
    vecs[7] = '{1'b1, cJmpHlt, 8'd5,  32'h40,       1, 0, 32'h0,        0, 1};
    vecs[8] = '{1'b0, cMov,    8'd5,  32'h0,        1, 0, 32'h0,        0, 0};
    vecs[9] = '{1'b1, cMov,    8'hFF, 32'h0,        1, 1, 32'hFF,       0, 0};

    $display("[TB] starting issue_ctrl bench");

    // Reset state
    doReset();
    checkOutput("reset fetch_pc", fetch_pc, 32'h0);
    checkOutput("reset iss_valid", 32'(iss_valid), 32'd0);
    checkOutput("reset halted", 32'(halted), 32'd0);
    checkOutput("reset illegal", 32'(illegal), 32'd0);
    checkOutput("reset sb_err", 32'(sb_err), 32'd0);

    // Single-instruction vectors, each from a fresh reset
    for (int i = 0; i < 10; i++) begin
      doReset();
      applyStimulus(vecs[i].valid, vecs[i].ctrl, 3'd0, 3'd1, vecs[i].len, vecs[i].imm, vecs[i].ready);
      checkOutput($sformatf("vec%0d iss_valid", i), 32'(iss_valid), 32'(vecs[i].expValid));
      tick();
      checkOutput($sformatf("vec%0d fetch_pc", i), fetch_pc, vecs[i].expPc);
      checkOutput($sformatf("vec%0d illegal", i), 32'(illegal), 32'(vecs[i].expIllegal));
      idle();
      tick();
      checkOutput($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].expHalted2));
    end

    // RAW stall cleared by writeback, no same-cycle bypass
    doReset();
    applyStimulus(1, cMov, 3'd1, 3'd0, 8'd5, 32'h1234, 1);
    checkOutput("raw mov issue", 32'(iss_valid), 32'd1);
    tick();
    checkOutput("raw pc after mov", fetch_pc, 32'h5);
    applyStimulus(1, cAddRR, 3'd1, 3'd0, 8'd2, 32'h0, 1);
    checkOutput("raw stall", 32'(iss_valid), 32'd0);
    tick();
    checkOutput("raw stall held", 32'(iss_valid), 32'd0);
    checkOutput("raw pc held", fetch_pc, 32'h5);
    wb_valid = 1'b1;
    wb_idx   = 3'd1;
    #1;
    checkOutput("raw no bypass", 32'(iss_valid), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    checkOutput("raw issue after wb", 32'(iss_valid), 32'd1);
    tick();
    checkOutput("raw pc after add", fetch_pc, 32'h7);

    // Jump with redirect bubble and negative displacement
    doReset();
    applyStimulus(1, cJmp, 3'd0, 3'd0, 8'd5, 32'h0B, 1);
    tick();
    checkOutput("jmp to 0x10", fetch_pc, 32'h10);
    applyStimulus(1, cMov, 3'd0, 3'd0, 8'd5, 32'h0, 1);
    checkOutput("jmp1 bubble", 32'(iss_valid), 32'd0);
    tick();
    checkOutput("jmp1 bubble pc", fetch_pc, 32'h10);
    applyStimulus(1, cJmp, 3'd0, 3'd0, 8'd5, 32'hFFFFFFF0, 1);
    checkOutput("jmp2 no issue", 32'(iss_valid), 32'd0);
    tick();
    checkOutput("jmp2 target", fetch_pc, 32'h5);
    applyStimulus(1, cMov, 3'd0, 3'd0, 8'd5, 32'h0, 1);
    checkOutput("jmp2 bubble", 32'(iss_valid), 32'd0);
    tick();
    checkOutput("jmp2 bubble pc", fetch_pc, 32'h5);
    checkOutput("after redirect issue", 32'(iss_valid), 32'd1);
    tick();
    checkOutput("after redirect pc", fetch_pc, 32'hA);

    // Backpressure holds offer and PC; counter increments only on accept
    doReset();
    applyStimulus(1, cAddI, 3'd0, 3'd0, 8'd5, 32'h7, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp valid held %0d", k), 32'(iss_valid), 32'd1);
      tick();
      checkOutput($sformatf("bp pc held %0d", k), fetch_pc, 32'h0);
    end
    applyStimulus(1, cAddI, 3'd0, 3'd0, 8'd5, 32'h7, 1);
    tick();
    checkOutput("bp pc accepted", fetch_pc, 32'h5);
    checkOutput("bp raw on eax", 32'(iss_valid), 32'd0);
    wb_valid = 1'b1;
    wb_idx   = 3'd0;
    tick();
    wb_valid = 1'b0;
    #1;
    checkOutput("bp single inc", 32'(iss_valid), 32'd1);

    // Halt drains pending write, then sticks
    doReset();
    applyStimulus(1, cMov, 3'd0, 3'd0, 8'd5, 32'h0, 1);
    tick();
    applyStimulus(1, cHlt, 3'd0, 3'd0, 8'd1, 32'h0, 1);
    checkOutput("hlt no issue", 32'(iss_valid), 32'd0);
    tick();
    idle();
    checkOutput("hlt pc held", fetch_pc, 32'h5);
    checkOutput("drain halted 0", 32'(halted), 32'd0);
    tick();
    checkOutput("drain still pending", 32'(halted), 32'd0);
    wb_valid = 1'b1;
    wb_idx   = 3'd0;
    tick();
    wb_valid = 1'b0;
    #1;
    checkOutput("drain sees empty", 32'(halted), 32'd0);
    tick();
    checkOutput("halted rises", 32'(halted), 32'd1);
    applyStimulus(1, cMov, 3'd1, 3'd0, 8'd5, 32'h0, 1);
    checkOutput("halted no issue", 32'(iss_valid), 32'd0);
    tick();
    tick();
    checkOutput("halted sticky", 32'(halted), 32'd1);
    checkOutput("halted pc", fetch_pc, 32'h5);

    // Saturation, writeback error, reset mid-operation
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, cMov, 3'd0, 3'd0, 8'd5, 32'h0, 1);
      checkOutput($sformatf("sat issue %0d", k), 32'(iss_valid), 32'd1);
      tick();
    end
    applyStimulus(1, cMov, 3'd0, 3'd0, 8'd5, 32'h0, 1);
    checkOutput("sat 4th stalls", 32'(iss_valid), 32'd0);
    tick();
    checkOutput("sat pc", fetch_pc, 32'd15);
    wb_valid = 1'b1;
    wb_idx   = 3'd0;
    #1;
    checkOutput("sat wb no bypass", 32'(iss_valid), 32'd0);
    tick();
    wb_valid = 1'b0;
    applyStimulus(1, cMov, 3'd0, 3'd0, 8'd5, 32'h0, 0);
    checkOutput("sat unblocked", 32'(iss_valid), 32'd1);
    wb_valid = 1'b1;
    wb_idx   = 3'd5;
    tick();
    wb_valid = 1'b0;
    #1;
    checkOutput("sb_err set", 32'(sb_err), 32'd1);
    tick();
    checkOutput("sb_err sticky", 32'(sb_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst pc", fetch_pc, 32'h0);
    checkOutput("midrst sb_err", 32'(sb_err), 32'd0);
    applyStimulus(1, cAddI, 3'd0, 3'd0, 8'd5, 32'h0, 1);
    checkOutput("midrst counters cleared", 32'(iss_valid), 32'd1);
    tick();
    checkOutput("midrst issue pc", fetch_pc, 32'h5);

    // Randomized run against the reference model
    doReset();
    foreach (mPend[r]) mPend[r] = 0;
    mPc     = 32'h0;
    mBubble = 0;
    mHeld   = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit nBubble, nHeld;
      if (!mHeld) begin
        rV   = ($urandom_range(0, 9) < 8);
        rJ   = ($urandom_range(0, 9) == 0);
        rMux = 1'($urandom_range(0, 1));
        rR1  = 1'($urandom_range(0, 1));
        rR2  = 1'($urandom_range(0, 1));
        rWe  = 1'($urandom_range(0, 1));
        rS1  = 3'($urandom_range(0, 3));
        rS2  = 3'($urandom_range(0, 3));
        rLen = 8'($urandom_range(1, 15));
        rImm = $urandom;
      end
      rRdy   = ($urandom_range(0, 3) != 0);
      rWbIdx = 3'($urandom_range(0, 3));
      doWb   = (mPend[rWbIdx] > 0) && ($urandom_range(0, 1) == 1);
      wb_valid = doWb;
      wb_idx   = rWbIdx;
      applyStimulus(rV, mkCtrl(rMux, rR1, rR2, rWe, rJ, 0), rS1, rS2, rLen, rImm, rRdy);

      nBubble = 0;
      nHeld   = 0;
      expV    = 0;
      if (mBubble) begin
        nBubble = 0;
      end else if (rV && rJ) begin
        mPc     = mPc + 32'(rLen) + rImm;
        nBubble = 1;
      end else if (rV) begin
        hz = (rR1 && mPend[rS1] > 0) || (rR2 && !rMux && mPend[rS2] > 0) || (rWe && mPend[rS1] >= 3);
        expV = !hz;
      end
      checkOutput($sformatf("rand %0d iss_valid", cyc), 32'(iss_valid), 32'(expV));
      if (expV && rRdy) begin
        mPc = mPc + 32'(rLen);
        if (rWe) mPend[rS1]++;
      end else if (expV) begin
        nHeld = 1;
      end
      if (doWb) mPend[rWbIdx]--;
      tick();
      mBubble = nBubble;
      mHeld   = nHeld;
      wb_valid = 1'b0;
      #1;
      checkOutput($sformatf("rand %0d fetch_pc", cyc), fetch_pc, mPc);
    end
    checkOutput("rand sb_err", 32'(sb_err), 32'd0);
    checkOutput("rand halted", 32'(halted), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
